// File: rtl/alu_shift_arbiter.sv
// alu_shift_arbiter: two-port round-robin front end for one shared left shifter, R = A << B[CNT_W-1:0].
// Latency: amount+1 cycles from accept to rsp_valid (always 1 cycle with ALU_SHIFT_FASTPATH_EN defined).
// Backpressure: result held in RESP until rsp_ready; neither requester is accepted while busy.
module alu_shift_arbiter #(
    parameter int N     = 3,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_r,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     r;
    logic             id;
    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             acc_id;
    logic [N-1:0]     acc_a;
    logic [CNT_W-1:0] acc_amt;
    logic             unused_b;
`ifndef ALU_SHIFT_FASTPATH_EN
    logic [CNT_W-1:0] cnt;
`endif

    // The requester not served last wins a contention; a lone valid requester always wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign accept  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign acc_id  = req1_ready;
    assign acc_a   = req0_ready ? req0_a : req1_a;
    assign acc_amt = req0_ready ? req0_b[CNT_W-1:0] : req1_b[CNT_W-1:0];

    // Upper shift-amount bits carry no meaning for this unit.
    assign unused_b = ^{req0_b[N-1:CNT_W], req1_b[N-1:CNT_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SHIFT_FASTPATH_EN
                    state_nxt = RESP;
`else
                    state_nxt = (acc_amt == '0) ? RESP : SHIFT;
`endif
                end
            end
`ifndef ALU_SHIFT_FASTPATH_EN
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r          <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            id         <= acc_id;
            last_grant <= acc_id;
`ifdef ALU_SHIFT_FASTPATH_EN
            r          <= acc_a << acc_amt;
`else
            r          <= acc_a;
`endif
        end
`ifndef ALU_SHIFT_FASTPATH_EN
        else if (state == SHIFT) begin
            r <= {r[N-2:0], 1'b0};
        end
`endif
    end

`ifndef ALU_SHIFT_FASTPATH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= acc_amt;
        end else if (state == SHIFT) begin
            cnt <= cnt - 1'b1;
        end
    end
`endif

    assign rsp_r  = r;
    assign rsp_id = id;

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Bench for alu_shift_arbiter: table-driven single requests, hold/backpressure, reset abort and contention.
// Expected results go into a scoreboard queue at accept and are checked when the response handshakes.
module tb_alu_shift_arbiter;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req1_valid = 1'b0;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic         rsp_ready = 1'b0;
    logic         req0_ready;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_id;
    logic [N-1:0] rsp_r;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] r;
    } vec_t;

    typedef struct {
        logic         id;
        logic [N-1:0] r;
        int           acc_cyc;
        int           amt;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    logic prev_vld = 1'b0;
    vec_t tbl[10];
    vec_t cv0[2];
    vec_t cv1[2];

    alu_shift_arbiter #(.N(N), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_r      (rsp_r),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int lat_exp(input int amt);
`ifdef ALU_SHIFT_FASTPATH_EN
        lat_exp = amt - amt;
`else
        lat_exp = amt;
`endif
    endfunction

    // Response monitor: latency on the rising edge of rsp_valid, data/id at the handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (rsp_valid && !prev_vld) begin
                if (sbq.size() == 0) check("unexpected_rsp", 1, 0);
                else check("latency", cyc - sbq[0].acc_cyc, lat_exp(sbq[0].amt));
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_handshake", 1, 0);
                end else begin
                    me = sbq.pop_front();
                    check("rsp_r", rsp_r, me.r);
                    check("rsp_id", rsp_id, me.id);
                end
            end
            prev_vld = rsp_valid;
        end
    end

    task automatic issue(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] r_exp, input bit push, input bit chk_now);
        int   w;
        exp_t e;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        w = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            check("accept_timeout", 1, 0);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        if (chk_now) check("ready_immediate", w, 0);
        @(posedge clk); #1;
        if (push) begin
            e.id = id; e.r = r_exp; e.acc_cyc = cyc; e.amt = int'(b[1:0]);
            sbq.push_back(e);
        end
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   w;
        int   j0;
        int   j1;
        logic wid;

        tbl[0] = '{1'b0, 3'b011, 3'b001, 3'b110};
        tbl[1] = '{1'b1, 3'b111, 3'b011, 3'b000};
        tbl[2] = '{1'b1, 3'b101, 3'b100, 3'b101};
        tbl[3] = '{1'b0, 3'b001, 3'b010, 3'b100};
        tbl[4] = '{1'b1, 3'b011, 3'b010, 3'b100};
        tbl[5] = '{1'b0, 3'b111, 3'b001, 3'b110};
        tbl[6] = '{1'b1, 3'b110, 3'b111, 3'b000};
        tbl[7] = '{1'b0, 3'b010, 3'b000, 3'b010};
        tbl[8] = '{1'b0, 3'b101, 3'b110, 3'b100};
        tbl[9] = '{1'b1, 3'b011, 3'b101, 3'b110};
        cv0[0] = '{1'b0, 3'b011, 3'b001, 3'b110};
        cv0[1] = '{1'b0, 3'b001, 3'b010, 3'b100};
        cv1[0] = '{1'b1, 3'b101, 3'b001, 3'b010};
        cv1[1] = '{1'b1, 3'b110, 3'b000, 3'b110};

        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_r", rsp_r, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].r, 1'b1, 1'b1);
            drain();
        end

        // Backpressure: result held 5 cycles, no grant while req1 waits.
        rsp_ready = 1'b0;
        issue(1'b0, 3'b011, 3'b001, 3'b110, 1'b1, 1'b1);
        req1_valid = 1'b1; req1_a = 3'b010; req1_b = 3'b001;
        w = 0;
        @(negedge clk);
        while (!rsp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("hold_rsp_seen", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_r", rsp_r, 3'b110);
            check("hold_rsp_id", rsp_id, 0);
            check("hold_no_ready", {req0_ready, req1_ready}, 0);
            check("hold_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_no_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        check("after_hs_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        e.id = 1'b1; e.r = 3'b100; e.acc_cyc = cyc; e.amt = 1;
        sbq.push_back(e);
        req1_valid = 1'b0;
        drain();

        // Reset in the middle of an operation: nothing may come out afterwards.
        rsp_ready = 1'b0;
        issue(1'b0, 3'b001, 3'b011, 3'b000, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_r", rsp_r, 0);
        check("abort_rsp_id", rsp_id, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Contention: both valid, expect 0,1,0,1 with req0 first after reset.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = cv0[0].a; req0_b = cv0[0].b;
        req1_valid = 1'b1; req1_a = cv1[0].a; req1_b = cv1[0].b;
        j0 = 0;
        j1 = 0;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            @(negedge clk);
            check("ready_exclusive", req0_ready & req1_ready, 0);
            while (!(req0_ready || req1_ready) && w < 50) begin
                @(negedge clk);
                check("ready_exclusive", req0_ready & req1_ready, 0);
                w++;
            end
            if (w >= 50) begin
                check("contention_timeout", 1, 0);
                break;
            end
            wid = req1_ready;
            check("rr_order", wid, k % 2);
            @(posedge clk); #1;
            e.id = wid;
            e.r = wid ? cv1[j1].r : cv0[j0].r;
            e.acc_cyc = cyc;
            e.amt = wid ? int'(cv1[j1].b[1:0]) : int'(cv0[j0].b[1:0]);
            sbq.push_back(e);
            if (wid) begin
                j1++;
                if (j1 < 2) begin req1_a = cv1[j1].a; req1_b = cv1[j1].b; end
                else req1_valid = 1'b0;
            end else begin
                j0++;
                if (j0 < 2) begin req0_a = cv0[j0].a; req0_b = cv0[j0].b; end
                else req0_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        repeat (5) @(negedge clk);
        check("final_idle_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
